cargo_stop_scheduler: RTL

CARGO_STOP_SCHEDULER -- requirements
Module: cargo_stop_scheduler

---
 rtl/cargo_stop_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cargo_stop_scheduler.sv
// Four-floor cargo lift stop scheduler with a LOOK policy over a pending-stop bitmap.
// Optional stall watchdog in MOVE_UP/MOVE_DOWN: define SCHED_TIMEOUT_EN.
module cargo_stop_scheduler #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_floor,
  output logic       req_ready,
  input  logic       floor_valid,
  input  logic [1:0] floor_id,
  input  logic       service_done,
  input  logic       emergencia,
  output logic [1:0] andar_atual,
  output logic [1:0] prox_parada,
  output logic       tem_destino,
  output logic       motor_subindo,
  output logic       motor_descendo,
  output logic       servico,
  output logic [3:0] pendentes,
  output logic       falha
);

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    MOVE_UP,
    MOVE_DOWN,
    SERVICE,
    FAULT
  } state_t;

  state_t     state;
  logic [3:0] pend;
  logic [1:0] andar;
  logic       dir;

  logic       accept;
  logic [3:0] set_mask;
  logic [3:0] clr_mask;
  logic [3:0] pend_eff;
  logic       up_found;
  logic       dn_found;
  logic [1:0] up_floor;
  logic [1:0] dn_floor;
  logic       timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // A request landing in the same cycle as its floor sensor must still stop the cab.
  always_comb begin
    accept   = req_valid && req_ready;
    set_mask = accept ? (4'b0001 << req_floor) : 4'b0000;
    pend_eff = pend | set_mask;
    clr_mask = (state == SERVICE && service_done && !emergencia) ? (4'b0001 << andar) : 4'b0000;
  end

  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_floor = andar;
    dn_floor = andar;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i] && (2'(i) > andar)) begin
        up_found = 1'b1;
        up_floor = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && (2'(i) < andar)) begin
        dn_found = 1'b1;
        dn_floor = 2'(i);
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] cnt;

  always_comb begin
    timeout_hit = (state == MOVE_UP || state == MOVE_DOWN) && !floor_valid &&
                  (cnt == 32'(TIMEOUT_CYCLES - 1));
  end

  // Counts cycles between floor sensors while moving; frozen during emergencia.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!emergencia) begin
      if ((state == MOVE_UP || state == MOVE_DOWN) && !floor_valid && !timeout_hit)
        cnt <= cnt + 32'd1;
      else
        cnt <= '0;
    end
  end

  assign falha = (state == FAULT);
`else
  assign timeout_hit = 1'b0;
  assign falha       = 1'b0;
`endif

  // Clear wins over a simultaneous request for the floor being serviced.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= '0;
      andar <= '0;
      dir   <= 1'b1;
    end else begin
      pend <= pend_eff & ~clr_mask;
      if (floor_valid)
        andar <= floor_id;
      if (!emergencia) begin
        case (state)
          IDLE: begin
            if (pend != 4'b0000)
              state <= DECIDE;
          end
          DECIDE: begin
            if (pend[andar]) begin
              state <= SERVICE;
            end else if (up_found && (dir || !dn_found)) begin
              state <= MOVE_UP;
              dir   <= 1'b1;
            end else if (dn_found) begin
              state <= MOVE_DOWN;
              dir   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          MOVE_UP: begin
            if (timeout_hit)
              state <= FAULT;
            else if (floor_valid) begin
              if (floor_id < andar)
                state <= DECIDE;
              else if (pend_eff[floor_id])
                state <= SERVICE;
            end
          end
          MOVE_DOWN: begin
            if (timeout_hit)
              state <= FAULT;
            else if (floor_valid) begin
              if (floor_id > andar)
                state <= DECIDE;
              else if (pend_eff[floor_id])
                state <= SERVICE;
            end
          end
          SERVICE: begin
            if (service_done)
              state <= DECIDE;
          end
          FAULT: state <= FAULT;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    if (dir)
      prox_parada = up_found ? up_floor : (dn_found ? dn_floor : andar);
    else
      prox_parada = dn_found ? dn_floor : (up_found ? up_floor : andar);
  end

  assign req_ready      = (state != FAULT);
  assign andar_atual    = andar;
  assign tem_destino    = (pend != 4'b0000);
  assign pendentes      = pend;
  assign motor_subindo  = (state == MOVE_UP) && !emergencia;
  assign motor_descendo = (state == MOVE_DOWN) && !emergencia;
  assign servico        = (state == SERVICE);

endmodule
